pipelined_adder: RTL and testbench

Parametrised, pipelined add/subtract unit for wide-operand datapath use (address generation, multi-cycle ALU extensions). Operands are split into equal slices; each pipeline stage adds one slice and forwards its carry to the next stage, giving a short critical path at a latency of STAGES cycles. A valid/ready handshake with full backpressure lets it sit between stalling pipeline stages. An optional flag output provides NZCV-style status.

---
 rtl/adder_pkg.sv | 16 +
 rtl/adder_slice.sv | 20 ++
 rtl/pipelined_adder.sv | 128 ++++++++++++
 tb/tb_pipelined_adder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit.
package adder_pkg;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // True when the operand splits into STAGES equal, non-empty slices.
  function automatic bit slice_width_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// One slice of the carry-chained adder: {c_out, sum} = a + (b ^ {SW{sub}}) + c_in.
module adder_slice
  import adder_pkg::*;
#(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          sub,
  input  logic          c_in,
  output logic [SW-1:0] sum,
  output logic          c_out
);

  logic [SW:0] total;

  assign total = {1'b0, a} + {1'b0, b ^ {SW{sub}}} + {{SW{1'b0}}, c_in};
  assign {c_out, sum} = total;

endmodule

// File: rtl/pipelined_adder.sv
// Slice-per-stage pipelined add/subtract with valid/ready backpressure.
// Define ADDER_FLAGS_EN to add the registered {N, Z, C, V} flags output.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y
`ifdef ADDER_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  localparam int SW = WIDTH / STAGES;

  if (!slice_width_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  // Whole pipe advances together; a stalled output freezes every stage.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic [WIDTH-1:0] a_in      [STAGES];
  logic [WIDTH-1:0] b_in      [STAGES];
  logic [WIDTH-1:0] y_in      [STAGES];
  logic             sub_in    [STAGES];
  logic             c_in      [STAGES];
  logic             v_in      [STAGES];
  logic [SW-1:0]    sum       [STAGES];
  logic             c_out     [STAGES];
  logic [WIDTH-1:0] y_next    [STAGES];

  logic [WIDTH-1:0] a_reg     [STAGES];
  logic [WIDTH-1:0] b_reg     [STAGES];
  logic [WIDTH-1:0] y_reg     [STAGES];
  logic             sub_reg   [STAGES];
  logic             carry_reg [STAGES];
  logic             valid_reg [STAGES];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign a_in[gi]   = a;
      assign b_in[gi]   = b;
      assign y_in[gi]   = '0;
      assign sub_in[gi] = sub;
      assign c_in[gi]   = sub;
      assign v_in[gi]   = in_valid;
    end else begin : g_body
      assign a_in[gi]   = a_reg[gi-1];
      assign b_in[gi]   = b_reg[gi-1];
      assign y_in[gi]   = y_reg[gi-1];
      assign sub_in[gi] = sub_reg[gi-1];
      assign c_in[gi]   = carry_reg[gi-1];
      assign v_in[gi]   = valid_reg[gi-1];
    end

    adder_slice #(.SW(SW)) u_slice (
      .a     (a_in[gi][gi*SW +: SW]),
      .b     (b_in[gi][gi*SW +: SW]),
      .sub   (sub_in[gi]),
      .c_in  (c_in[gi]),
      .sum   (sum[gi]),
      .c_out (c_out[gi])
    );

    // Slices above gi are still zero in y_in, so OR-ing places this slice.
    assign y_next[gi] = y_in[gi] | (WIDTH'(sum[gi]) << (gi * SW));

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        valid_reg[gi] <= 1'b0;
        a_reg[gi]     <= '0;
        b_reg[gi]     <= '0;
        y_reg[gi]     <= '0;
        sub_reg[gi]   <= 1'b0;
        carry_reg[gi] <= 1'b0;
      end else if (adv) begin
        valid_reg[gi] <= v_in[gi];
        a_reg[gi]     <= a_in[gi];
        b_reg[gi]     <= b_in[gi];
        y_reg[gi]     <= y_next[gi];
        sub_reg[gi]   <= sub_in[gi];
        carry_reg[gi] <= c_out[gi];
      end
    end
  end

  assign out_valid = valid_reg[STAGES-1];
  assign y         = y_reg[STAGES-1];

`ifdef ADDER_FLAGS_EN
  localparam int LAST = STAGES - 1;

  flags_t flags_next;
  flags_t flags_reg;

  // Overflow: effective operand signs agree but the result sign differs.
  assign flags_next.n = y_next[LAST][WIDTH-1];
  assign flags_next.z = (y_next[LAST] == '0);
  assign flags_next.c = c_out[LAST];
  assign flags_next.v = (a_in[LAST][WIDTH-1] == (b_in[LAST][WIDTH-1] ^ sub_in[LAST])) &&
                        (y_next[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_reg <= '0;
    end else if (adv) begin
      flags_reg <= flags_next;
    end
  end

  assign flags = flags_reg;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (default 32-bit, 4 stages).
module tb_pipelined_adder;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
`ifdef ADDER_FLAGS_EN
  logic [3:0]       flags;
`endif

  int checks   = 0;
  int failures = 0;
  int n_out;
  int run_len;
  int max_run;
  bit last_acc;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
`ifdef ADDER_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One cycle: score the output transfer and record the input transfer, then advance.
  task automatic tick();
    #1;
    last_acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("unexpected_out", out_valid, 1'b0);
      end else begin
        $display("xfer y=%h expected=%h", y, exp_q[0]);
        check("stream_y", y, exp_q.pop_front());
      end
    end
    if (out_valid) run_len++;
    else run_len = 0;
    if (run_len > max_run) max_run = run_len;
    if (last_acc) exp_q.push_back(sub ? (a - b) : (a + b));
    @(posedge clk);
    #1;
  endtask

  task automatic run_single(input string tag, input logic [31:0] av, input logic [31:0] bv,
                            input logic sv, input logic [31:0] ey, input logic [3:0] ef);
    int lat;
    a        = av;
    b        = bv;
    sub      = sv;
    in_valid = 1'b1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, lat, STAGES);
    check({tag, "_y"}, y, ey);
`ifdef ADDER_FLAGS_EN
    check({tag, "_flags"}, flags, ef);
`endif
    $display("op %s a=%h b=%h sub=%0d y=%h lat=%0d exp_flags=%b", tag, av, bv, sv, y, lat, ef);
    @(posedge clk);
    #1;
    check({tag, "_consumed"}, out_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int guard;
    reset_n   = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    out_ready = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_y", y, 0);
    check("rst_in_ready", in_ready, 1'b1);
`ifdef ADDER_FLAGS_EN
    check("rst_flags", flags, 0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Directed vectors: expected y and {N,Z,C,V} computed by hand.
    run_single("add_small", 32'd4,          32'd3,          1'b0, 32'd7,          4'b0000);
    run_single("add_mixed", 32'h0FFFFFF0,   32'h1EFFE012,   1'b0, 32'h2EFFE002,   4'b0000);
    run_single("add_ripple",32'hFFFFFFFF,   32'h5EFFFFFF,   1'b0, 32'h5EFFFFFE,   4'b0010);
    run_single("sub_borrow",32'd0,          32'd10,         1'b1, 32'hFFFFFFF6,   4'b1000);
    run_single("sub_pos",   32'd10,         32'd5,          1'b1, 32'd5,          4'b0010);
    run_single("sub_ovf",   32'h80000000,   32'd1,          1'b1, 32'h7FFFFFFF,   4'b0011);
    run_single("sub_zero",  32'd5,          32'd5,          1'b1, 32'd0,          4'b0110);

    // Back-to-back stream of 8 random ops.
    n_out   = 0;
    run_len = 0;
    max_run = 0;
    for (int i = 0; i < 8; i++) begin
      a        = $urandom;
      b        = $urandom;
      sub      = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 12 && exp_q.size() > 0; i++) tick();
    check("stream_count", n_out, 8);
    check("stream_consecutive", max_run, 8);
    check("stream_left", exp_q.size(), 0);

    // Backpressure: fill the pipe with out_ready low, hold, then drain.
    out_ready = 1'b0;
    n_out     = 0;
    idx       = 0;
    for (int i = 0; i < STAGES; i++) begin
      a        = 32'(idx * 1000 + 1);
      b        = 32'(idx * 7);
      sub      = 1'(idx % 2);
      in_valid = 1'b1;
      tick();
      if (last_acc) idx++;
    end
    a        = 32'(idx * 1000 + 1);
    b        = 32'(idx * 7);
    sub      = 1'(idx % 2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_no_accept", last_acc, 1'b0);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_y_stable", y, exp_q[0]);
    end
    out_ready = 1'b1;
    guard     = 0;
    while ((idx < 7 || exp_q.size() > 0) && guard < 40) begin
      if (idx < 7) begin
        a        = 32'(idx * 1000 + 1);
        b        = 32'(idx * 7);
        sub      = 1'(idx % 2);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (last_acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    check("bp_out_count", n_out, 7);
    check("bp_left", exp_q.size(), 0);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      a        = 32'(100 + i);
      b        = 32'(200 + i);
      sub      = 1'b0;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_y", y, 0);
    check("midrst_in_ready", in_ready, 1'b1);
    exp_q.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    n_out = 0;
    for (int i = 0; i < 8; i++) tick();
    check("midrst_no_stale", n_out, 0);
    run_single("after_rst", 32'd123, 32'd456, 1'b0, 32'd579, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
